detect_sched: RTL and testbench

DETECT_SCHED -- requirements
Module: detect_sched

---
 rtl/detect_sched_pkg.sv | 17 +
 rtl/detect_sched_if.sv | 43 ++++
 rtl/detect_sched_rr_arb2.sv | 31 +++
 rtl/detect_sched.sv | 129 ++++++++++++
 tb/tb_detect_sched.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/detect_sched_pkg.sv
// Shared definitions for the serial detector scheduler: controller state
// encoding, detector code width, result counter width and default word length.
package detect_sched_pkg;

    localparam int W_DEFAULT = 8;
    localparam int CODE_W    = 3;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/detect_sched_if.sv
// Bundle of requester handshakes, detector drive/return and result signals.
//
// Handshake: a requester raises reqN_valid with reqN_data and holds both
// stable until it sees reqN_ready; the word transfers on the rising edge
// where valid & ready are both high. ready is combinational and may depend
// on valid. res_valid is a one-cycle pulse with no back-pressure.
interface detect_sched_if import detect_sched_pkg::*; #(
    parameter int W = W_DEFAULT
) ();

    logic              req0_valid;
    logic [W-1:0]      req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [W-1:0]      req1_data;
    logic              req1_ready;

    logic              det_clr;
    logic              det_a;
    logic [CODE_W-1:0] det_x;

    logic              res_valid;
    logic              res_id;
    logic [CODE_W-1:0] res_code;
    logic [CNT_W-1:0]  res_cnt;
    logic              busy;
    state_t            dbg_state;

    // Requester and detector side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, det_x,
        input  req0_ready, req1_ready, det_clr, det_a,
        input  res_valid, res_id, res_code, res_cnt, busy, dbg_state
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, det_x,
        output req0_ready, req1_ready, det_clr, det_a,
        output res_valid, res_id, res_code, res_cnt, busy, dbg_state
    );

endinterface

// File: rtl/detect_sched_rr_arb2.sv
// Two-way round-robin grant. ptr_q=0 favours req0 when both request;
// an update strobe points the favour away from the requester just served.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt
);

    logic ptr_q;

    // Pointer register: after serving upd_id, favour the other requester
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (upd) begin
            ptr_q <= ~upd_id;
        end
    end

    // One-hot grant: a lone request wins, a tie goes to the favoured side
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/detect_sched.sv
// Serialises words from two requesters MSB first into an external sequence
// detector, clearing it before each word, and reports the last nonzero
// detector code and the number of nonzero code samples for that word.
module detect_sched import detect_sched_pkg::*; #(
    parameter int W = W_DEFAULT   // must match the W of the connected bus
) (
    input  logic         clk,
    input  logic         rst,
    detect_sched_if.slave bus
);

    localparam logic [3:0] K_LAST = 4'(W - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      sh_q;
    logic [3:0]        k_q;
    logic              id_q;
    logic [CODE_W-1:0] code_acc_q;
    logic [CNT_W-1:0]  cnt_acc_q;
    logic              res_id_q;
    logic [CODE_W-1:0] res_code_q;
    logic [CNT_W-1:0]  res_cnt_q;
    logic              armed_q;

    logic [1:0]        arb_req;
    logic [1:0]        gnt;
    logic              xfer;
    logic              upd;
    logic              sample;
    logic              hit;

    // Requests only reach the arbiter in IDLE, and not in the first cycle after reset
    always_comb begin
        arb_req = {bus.req1_valid, bus.req0_valid} & {2{(state_q == ST_IDLE) && armed_q}};
        upd     = (state_q == ST_DONE);
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .upd    (upd),
        .upd_id (id_q),
        .gnt    (gnt)
    );

    // State register; armed_q blocks the grant for one cycle after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_SHIFT;
            ST_SHIFT: if (k_q == K_LAST) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake, detector drive and status outputs. The detector code seen in
    // SHIFT cycle k reflects bit k-1, and DRAIN sees the last bit.
    always_comb begin
        xfer           = |gnt;
        bus.req0_ready = gnt[0];
        bus.req1_ready = gnt[1];
        bus.det_a      = (state_q == ST_SHIFT) ? sh_q[W-1] : 1'b0;
        bus.det_clr    = !rst || (state_q == ST_CLEAR);
        sample         = ((state_q == ST_SHIFT) && (k_q != 4'd0)) || (state_q == ST_DRAIN);
        hit            = sample && (bus.det_x != '0);
        bus.res_valid  = (state_q == ST_DONE);
        bus.busy       = (state_q != ST_IDLE);
        bus.res_id     = res_id_q;
        bus.res_code   = res_code_q;
        bus.res_cnt    = res_cnt_q;
        bus.dbg_state  = state_q;
    end

    // Word capture, MSB-first shifter and code/count accumulation
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_q       <= '0;
            k_q        <= 4'd0;
            id_q       <= 1'b0;
            code_acc_q <= '0;
            cnt_acc_q  <= '0;
        end else if (xfer) begin
            sh_q       <= gnt[1] ? bus.req1_data : bus.req0_data;
            id_q       <= gnt[1];
            k_q        <= 4'd0;
            code_acc_q <= '0;
            cnt_acc_q  <= '0;
        end else begin
            if (state_q == ST_SHIFT) begin
                sh_q <= {sh_q[W-2:0], 1'b0};
                k_q  <= k_q + 4'd1;
            end
            if (hit) begin
                code_acc_q <= bus.det_x;
                cnt_acc_q  <= cnt_acc_q + 4'd1;
            end
        end
    end

    // Result registers load on the DRAIN->DONE edge (folding in the last
    // sample) so they are valid with res_valid and held until the next word
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_id_q   <= 1'b0;
            res_code_q <= '0;
            res_cnt_q  <= '0;
        end else if (state_q == ST_DRAIN) begin
            res_id_q   <= id_q;
            res_code_q <= hit ? bus.det_x : code_acc_q;
            res_cnt_q  <= cnt_acc_q + CNT_W'(hit);
        end
    end

endmodule

// File: tb/tb_detect_sched.sv
// Bench for detect_sched: sequence detector load (hits 101 -> 1, 1001 -> 2,
// 1000 -> 3, restarting after each hit), directed scenarios and random words
// checked against a bit-string reference model.
module tb_detect_sched;
    import detect_sched_pkg::*;

    localparam int W   = 8;
    localparam int LAT = W + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert   = 0;
    int   n_fail     = 0;
    int   pulse_cnt  = 0;
    int   exp_pulses = 0;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    detect_sched_if #(.W(W)) bus ();

    detect_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sequence detector load, reset by det_clr
    typedef enum logic [2:0] {D_IDLE, D_1, D_10, D_100, D_101, D_1001, D_1000} det_t;
    det_t ds;

    always_ff @(posedge clk) begin
        if (bus.det_clr) ds <= D_IDLE;
        else begin
            case (ds)
                D_IDLE:  ds <= bus.det_a ? D_1    : D_IDLE;
                D_1:     ds <= bus.det_a ? D_1    : D_10;
                D_10:    ds <= bus.det_a ? D_101  : D_100;
                D_100:   ds <= bus.det_a ? D_1001 : D_1000;
                default: ds <= bus.det_a ? D_1    : D_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.det_x = 3'd0;
        case (ds)
            D_101:   bus.det_x = 3'd1;
            D_1001:  bus.det_x = 3'd2;
            D_1000:  bus.det_x = 3'd3;
            default: bus.det_x = 3'd0;
        endcase
    end

    // Count every result pulse while out of reset
    always @(posedge clk) begin
        if (rst && bus.res_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Reference model: scan bits MSB first keeping the bits seen since the
    // last hit; a hit on a 101, 1001 or 1000 suffix restarts the history
    function automatic void ref_model(input logic [W-1:0] d, output int code, output int cnt);
        int hist;
        hist = 0;
        code = 0;
        cnt  = 0;
        for (int k = W - 1; k >= 0; k--) begin
            hist = ((hist << 1) | int'(d[k])) & 15;
            if ((hist & 7) == 5)   begin code = 1; cnt++; hist = 0; end
            else if (hist == 9)    begin code = 2; cnt++; hist = 0; end
            else if (hist == 8)    begin code = 3; cnt++; hist = 0; end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic drive(input bit id, input logic v, input logic [W-1:0] d);
        if (id) begin bus.req1_valid = v; bus.req1_data = d; end
        else    begin bus.req0_valid = v; bus.req0_data = d; end
    endtask

    // Wait (bounded) for id's ready; n returns cycles waited
    task automatic wait_grant(input bit id, output int n);
        n = 0;
        #1;
        while (rdy(id) !== 1'b1 && n < 60) begin tick(); n++; end
        chk("grant", rdy(id), 1);
        chk("grant_other", rdy(!id), 0);
    endtask

    // Called in the cycle after the accept edge (CLEAR); follows the word to its result
    task automatic finish_word(input bit id, input int exp_code, input int exp_cnt);
        int n;
        int bad;
        n   = 1;
        bad = 0;
        while (bus.res_valid !== 1'b1 && n < 40) begin
            if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
                bus.det_clr !== 1'(n == 1)) bad++;
            tick();
            n++;
        end
        chk("latency", n, LAT);
        chk("busy_phase", bad, 0);
        chk("res_id", bus.res_id, id);
        chk("res_code", bus.res_code, exp_code);
        chk("res_cnt", bus.res_cnt, exp_cnt);
        exp_pulses++;
        tick();
        chk("res_valid_pulse", bus.res_valid, 0);
        chk("idle_after_done", bus.busy, 0);
        chk("res_hold", bus.res_cnt, exp_cnt);
    endtask

    task automatic send(input bit id, input logic [W-1:0] d, input int exp_code, input int exp_cnt);
        int n;
        drive(id, 1'b1, d);
        wait_grant(id, n);
        tick();
        drive(id, 1'b0, d);
        finish_word(id, exp_code, exp_cnt);
    endtask

    // Directed and random stimulus
    initial begin
        int n, c, k;
        logic [W-1:0] d;
        bit id;

        // Reset with req0 already offering 10100000
        rst = 1'b0;
        drive(1, 1'b0, '0);
        drive(0, 1'b1, 8'b10100000);
        repeat (3) tick();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_code", bus.res_code, 0);
        chk("rst_res_cnt", bus.res_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_det_a", bus.det_a, 0);
        chk("rst_det_clr", bus.det_clr, 1);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_state", bus.dbg_state, ST_IDLE);
        rst = 1'b1;
        #1;
        chk("first_cycle_no_grant", bus.req0_ready, 0);
        tick();
        chk("second_cycle_grant", bus.req0_ready, 1);
        tick();
        drive(0, 1'b0, 8'b10100000);
        finish_word(0, 1, 1);

        // req1 words
        send(1, 8'b10010000, 2, 1);
        send(1, 8'b10000000, 3, 1);

        // Both valid and held: req0, req1, req0 at 12-cycle spacing
        drive(0, 1'b1, 8'b10110100);
        drive(1, 1'b1, 8'b10010000);
        wait_grant(0, n);
        chk("rr_first_wait", n, 0);
        tick();
        finish_word(0, 1, 2);
        drive(0, 1'b1, 8'b10000000);
        wait_grant(1, n);
        chk("rr_spacing_1", n, 0);
        tick();
        finish_word(1, 2, 1);
        wait_grant(0, n);
        chk("rr_spacing_2", n, 0);
        tick();
        drive(0, 1'b0, 8'b10000000);
        drive(1, 1'b0, 8'b10010000);
        finish_word(0, 3, 1);

        // All ones and a double hit
        send(0, 8'b11111111, 0, 0);
        send(0, 8'b10110100, 1, 2);

        // req1 raises valid while req0's word is in flight
        drive(0, 1'b1, 8'b11111111);
        wait_grant(0, n);
        tick();
        drive(0, 1'b0, 8'b11111111);
        drive(1, 1'b1, 8'b10110100);
        finish_word(0, 0, 0);
        wait_grant(1, n);
        chk("held_grant_wait", n, 0);
        tick();
        drive(1, 1'b0, 8'b10110100);
        finish_word(1, 1, 2);

        // Reset in SHIFT cycle 4 aborts the word
        drive(0, 1'b1, 8'b10100000);
        wait_grant(0, n);
        repeat (6) tick();
        chk("abort_in_shift", bus.busy, 1);
        rst = 1'b0;
        tick();
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_det_clr", bus.det_clr, 1);
        chk("abort_res_id", bus.res_id, 0);
        chk("abort_res_cnt", bus.res_cnt, 0);
        rst = 1'b1;
        #1;
        chk("abort_no_grant", bus.req0_ready, 0);
        tick();
        chk("abort_regrant", bus.req0_ready, 1);
        tick();
        drive(0, 1'b0, 8'b10100000);
        finish_word(0, 1, 1);

        // Random words from random requesters with random gaps
        for (int i = 0; i < 24; i++) begin
            id = 1'($urandom_range(0, 1));
            d  = W'($urandom_range(0, (1 << W) - 1));
            ref_model(d, c, k);
            send(id, d, c, k);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        chk("res_valid_count", pulse_cnt, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
